dft24_scheduler: RTL and testbench

Sequencing controller for the 24-point DFT core. On `start` it waits for the input sample buffer to fill, then steps the twiddle-factor index `k` from 0 to 11, one index per enabled cycle, and issues one butterfly operation per index. It tracks each operation through the fixed-latency multiply/accumulate datapath and generates the paired output-buffer writes for X[2k] and X[2k+1]. The block sits between the sample buffer, the twiddle ROM, the datapath and the result buffer; it contains no arithmetic itself.

---
 rtl/dft24_scheduler.sv | 131 +++++++++++++
 tb/tb_dft24_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dft24_scheduler.sv
// Sequencing controller for the 24-point DFT core: issue of twiddle indices 0..11 and paired result writes.
// Optional abort support is enabled by defining DFT_SCHED_ABORT_EN.
//
// state   | meaning
// IDLE    | waiting for start, all outputs quiet
// WAIT_IN | transform requested, waiting for the sample buffer to fill
// ISSUE   | presenting twiddle index k = 0..11, one per unstalled cycle
// DRAIN   | waiting for the in-flight operations to reach the result buffer
// DONE    | one-cycle completion pulse
module dft24_scheduler #(
  parameter int PIPE_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       in_full,
  input  logic       out_stall,
  output logic       in_consume,
  output logic [4:0] tw_k,
  output logic       issue_valid,
  output logic       pipe_en,
  output logic       wr_en,
  output logic [4:0] wr_addr0,
  output logic [4:0] wr_addr1,
  output logic       busy,
  output logic       done
);

`ifdef DFT_SCHED_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  // Every tracker entry except the head, used to detect the final write.
  localparam logic [PIPE_LAT-1:0] REST_MASK = {PIPE_LAT{1'b1}} >> 1;

  typedef enum logic [2:0] {IDLE, WAIT_IN, ISSUE, DRAIN, DONE} state_t;

  state_t               state, state_nx;
  logic [3:0]           cnt, cnt_nx;
  logic [PIPE_LAT-1:0]  tv;
  logic [3:0]           tk [PIPE_LAT];
  logic                 active;
  logic                 abort_act;

  assign active    = (state == WAIT_IN) || (state == ISSUE) || (state == DRAIN);
  assign abort_act = ABORT_EN && abort && active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    issue_valid = 1'b0;
    in_consume  = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = WAIT_IN;
      end
      WAIT_IN: begin
        busy = 1'b1;
        if (in_full && !out_stall) begin
          state_nx = ISSUE;
          cnt_nx   = 4'd0;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (!out_stall) begin
          issue_valid = 1'b1;
          if (cnt == 4'd11) begin
            in_consume = 1'b1;
            state_nx   = DRAIN;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!out_stall && ((tv & REST_MASK) == '0)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort_act) begin
      state_nx = IDLE;
      cnt_nx   = 4'd0;
    end
  end

  // In-flight tracker: entry 0 takes the issue, entry PIPE_LAT-1 is the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tk[i] <= 4'd0;
    end else if (abort_act) begin
      tv <= '0;
    end else if (!out_stall) begin
      tv[0] <= issue_valid;
      tk[0] <= cnt;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tv[i] <= tv[i-1];
        tk[i] <= tk[i-1];
      end
    end
  end

  assign pipe_en  = !out_stall;
  assign wr_en    = tv[PIPE_LAT-1] && !out_stall;
  assign wr_addr0 = wr_en ? {tk[PIPE_LAT-1], 1'b0} : 5'd0;
  assign wr_addr1 = wr_en ? {tk[PIPE_LAT-1], 1'b1} : 5'd0;
  // The counter stops on 11, so outside ISSUE it still holds the last issued index.
  assign tw_k     = (state == IDLE) ? 5'd0 : {1'b0, cnt};

endmodule

// File: tb/tb_dft24_scheduler.sv
// Directed self-checking bench for dft24_scheduler (PIPE_LAT = 3).
// Expected per-cycle values come from the stall-free timeline, shifted by input delay and stall cycles.
module tb_dft24_scheduler;
  localparam int L = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, in_full, out_stall;
  logic       in_consume, issue_valid, pipe_en, wr_en, busy, done;
  logic [4:0] tw_k, wr_addr0, wr_addr1;

  int n_cmp = 0;
  int n_err = 0;

  dft24_scheduler #(.PIPE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_full(in_full),
    .out_stall(out_stall), .in_consume(in_consume), .tw_k(tw_k),
    .issue_valid(issue_valid), .pipe_en(pipe_en), .wr_en(wr_en),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // c = cycle relative to the start pulse, d = in_full low cycles, s0/slen = stall window,
  // xs = cycle of an extra start pulse, ab = cycle of the abort pulse (-1 = none).
  task automatic run_seq(input int d, input int s0, input int slen, input int xs,
                         input int ab, input string nm);
    int c = 0, e = 0, nst = 0, nwr = 0, exp_nwr = 12;
    bit stl, fin = 1'b0, post_ab;
    logic eb, ed, eiv, eic, ewr;
    while (!fin && c < 120) begin
      @(negedge clk);
      start     = (c == 0) || (c == xs);
      in_full   = (d == 0) || (c > d && c < d + 4);
      stl       = (c >= s0) && (c < s0 + slen);
      out_stall = stl;
      abort     = (c == ab);
      if (c == 0) e = 0;
      else if (c <= d + 1) e = 1;
      else e = c - d - nst;
      #1;
      post_ab = 1'b0;
`ifdef DFT_SCHED_ABORT_EN
      post_ab = (ab >= 0) && (c > ab);
      exp_nwr = (ab >= 0) ? (ab - 2 - L + 1) : 12;
`endif
      eb  = (e >= 1) && (e <= 13 + L) && !post_ab;
      ed  = (e == 14 + L) && !stl && !post_ab;
      eiv = (e >= 2) && (e <= 13) && !stl && !post_ab;
      eic = (e == 13) && !stl && !post_ab;
      ewr = (e >= 2 + L) && (e <= 13 + L) && !stl && !post_ab;
      chk($sformatf("%s c%0d busy", nm, c), busy, eb);
      chk($sformatf("%s c%0d done", nm, c), done, ed);
      chk($sformatf("%s c%0d issue_valid", nm, c), issue_valid, eiv);
      chk($sformatf("%s c%0d in_consume", nm, c), in_consume, eic);
      chk($sformatf("%s c%0d wr_en", nm, c), wr_en, ewr);
      chk($sformatf("%s c%0d pipe_en", nm, c), pipe_en, !stl);
      if (post_ab)
        chk($sformatf("%s c%0d tw_k idle", nm, c), tw_k, 0);
      else if (e == 0)
        chk($sformatf("%s c%0d tw_k idle", nm, c), tw_k, 0);
      else if (e >= 2)
        chk($sformatf("%s c%0d tw_k", nm, c), tw_k, (e - 2 > 11) ? 11 : e - 2);
      if (ewr) begin
        chk($sformatf("%s c%0d wr_addr0", nm, c), wr_addr0, 2 * (e - 2 - L));
        chk($sformatf("%s c%0d wr_addr1", nm, c), wr_addr1, 2 * (e - 2 - L) + 1);
      end
      if (wr_en) nwr++;
      if (stl) nst++;
      if (post_ab) fin = (c >= ab + 20);
      else if (!stl && e == 14 + L) fin = 1'b1;
      c++;
    end
    chk($sformatf("%s completed in budget", nm), fin, 1);
    chk($sformatf("%s write count", nm), nwr, exp_nwr);
    start = 1'b0; abort = 1'b0; out_stall = 1'b0;
  endtask

  task automatic reset_mid();
    int nwr = 0, ndone = 0, nbusy = 0;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      start = (c == 0); in_full = 1'b1; out_stall = 1'b0; abort = 1'b0;
      #1;
    end
    chk("rst_mid tw_k before reset", tw_k, 4);
    chk("rst_mid issue_valid before reset", issue_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid busy", busy, 0);
    chk("rst_mid tw_k", tw_k, 0);
    chk("rst_mid issue_valid", issue_valid, 0);
    chk("rst_mid wr_en", wr_en, 0);
    chk("rst_mid wr_addr0", wr_addr0, 0);
    chk("rst_mid wr_addr1", wr_addr1, 0);
    chk("rst_mid in_consume", in_consume, 0);
    chk("rst_mid done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (wr_en) nwr++;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("rst_mid writes after reset", nwr, 0);
    chk("rst_mid done after reset", ndone, 0);
    chk("rst_mid busy after reset", nbusy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_full = 1'b0; out_stall = 1'b1;
    #2;
    chk("reset busy", busy, 0);
    chk("reset tw_k", tw_k, 0);
    chk("reset issue_valid", issue_valid, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_addr0", wr_addr0, 0);
    chk("reset wr_addr1", wr_addr1, 0);
    chk("reset in_consume", in_consume, 0);
    chk("reset done", done, 0);
    chk("reset pipe_en stalled", pipe_en, 0);
    out_stall = 1'b0;
    #1;
    chk("reset pipe_en free", pipe_en, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(0, -10, 0, -1, -1, "basic");
    run_seq(5, -10, 0, -1, -1, "infull_late");
    run_seq(0, 8, 2, -1, -1, "stall_k6");
    run_seq(0, -10, 0, 5, -1, "restart_ignored");
    run_seq(0, -10, 0, -1, -1, "back_to_back");
    reset_mid();
    run_seq(0, -10, 0, -1, -1, "after_reset");
    run_seq(0, -10, 0, -1, 10, "abort_k8");
    run_seq(0, -10, 0, -1, -1, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
